// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fs_state_e    : fetch controller states (FETCH / HOLD / DRAIN)
//   DEF_RESET_PC  : default PC loaded on reset
//   DEF_NOP_INST  : default bubble instruction (sll $0,$0,0)
//   pc_plus4()    : sequential PC increment, wraps mod 2^32
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_HOLD  = 2'd1,
    FS_DRAIN = 2'd2
  } fs_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_branch_target_calc.sv
// Branch target adder: target = PC+4 of the branch + (sign-extended
// 16-bit word offset << 2), modulo 2^32. Purely combinational so EX can
// reuse it for jump/branch debug.
//   br_pc4_i   in  32  PC+4 of the branch instruction
//   br_imm16_i in  16  branch offset field (words, signed)
//   target_o   out 32  resolved branch target byte address
module branch_target_calc (
  input  logic [31:0] br_pc4_i,
  input  logic [15:0] br_imm16_i,
  output logic [31:0] target_o
);

  logic signed [31:0] off_s;

  assign off_s    = {{14{br_imm16_i[15]}}, br_imm16_i, 2'b00};
  assign target_o = br_pc4_i + $unsigned(off_s);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC,
// drives a req/ack instruction-memory port and loads the IF/ID register.
// All state changes on the falling clock edge, like the other pipeline
// registers; reset is asynchronous and active-high.
//   clk, rst            clock (negedge active) / async reset
//   stall_if            hazard unit: hold IF/ID, do not consume a new instr
//   branch_taken        EX: branch resolved taken this cycle
//   br_pc4, br_imm16    EX: branch PC+4 and offset field
//   imem_req/imem_addr  fetch request and word-aligned byte address
//   imem_ack/imem_rdata memory response (data valid with ack)
//   ifid_inst/pc4/valid IF/ID register (valid=0 marks a bubble)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        branch_taken,
  input  logic [31:0] br_pc4,
  input  logic [15:0] br_imm16,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  fs_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] target;
  logic [31:0] pc4;

  branch_target_calc u_btc (
    .br_pc4_i   (br_pc4),
    .br_imm16_i (br_imm16),
    .target_o   (target)
  );

  assign pc4 = pc_plus4(pc_q);

  // In DRAIN the address stays on the old PC until the outstanding request
  // completes; the redirect target waits in redirect_q.
  assign imem_req   = ((state_q == FS_FETCH) || (state_q == FS_DRAIN)) && !rst;
  assign imem_addr  = pc_q;
  assign ifid_inst  = ifid_inst_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;

  // Next-state logic: branch_taken outranks stall_if in every state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = redirect_q;
    hold_buf_d   = hold_buf_q;
    hold_pc4_d   = hold_pc4_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    case (state_q)
      FS_FETCH: begin
        if (branch_taken) begin
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          if (imem_ack) begin
            // Wrong-path instruction arrived with the redirect: drop it.
            pc_d = target;
          end else begin
            redirect_d = target;
            state_d    = FS_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc4;
          if (stall_if) begin
            // ID is busy: park the fetched word so it is not lost.
            hold_buf_d = imem_rdata;
            hold_pc4_d = pc4;
            state_d    = FS_HOLD;
          end else begin
            ifid_inst_d  = imem_rdata;
            ifid_pc4_d   = pc4;
            ifid_valid_d = 1'b1;
          end
        end else if (!stall_if) begin
          // ID consumed its instruction and nothing new arrived.
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
        end
      end

      FS_HOLD: begin
        if (branch_taken) begin
          pc_d         = target;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          state_d      = FS_FETCH;
        end else if (!stall_if) begin
          ifid_inst_d  = hold_buf_q;
          ifid_pc4_d   = hold_pc4_q;
          ifid_valid_d = 1'b1;
          state_d      = FS_FETCH;
        end
      end

      FS_DRAIN: begin
        ifid_inst_d  = NOP_INST;
        ifid_valid_d = 1'b0;
        if (branch_taken) begin
          redirect_d = target;
        end
        if (imem_ack) begin
          // A redirect on the same edge as the ack is the latest one.
          pc_d    = branch_taken ? target : redirect_q;
          state_d = FS_FETCH;
        end
      end

      default: begin
        state_d = FS_FETCH;
      end
    endcase
  end

  // State register: falling edge, asynchronous reset.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FS_FETCH;
      pc_q         <= RESET_PC;
      redirect_q   <= 32'h0;
      hold_buf_q   <= 32'h0;
      hold_pc4_q   <= 32'h0;
      ifid_inst_q  <= NOP_INST;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      hold_buf_q   <= hold_buf_d;
      hold_pc4_q   <= hold_pc4_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b1;
  logic        rst;
  logic        stall_if;
  logic        branch_taken;
  logic [31:0] br_pc4;
  logic [15:0] br_imm16;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  // Second instance with RESET_PC at the top of the address space.
  logic        w_stall;
  logic        w_branch;
  logic [31:0] w_br_pc4;
  logic [15:0] w_br_imm16;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic [31:0] w_inst;
  logic [31:0] w_pc4;
  logic        w_valid;

  int checks = 0;
  int errors = 0;
  int lat;
  int cnt;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_if     (stall_if),
    .branch_taken (branch_taken),
    .br_pc4       (br_pc4),
    .br_imm16     (br_imm16),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ifid_inst    (ifid_inst),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0000)) u_wrap (
    .clk          (clk),
    .rst          (rst),
    .stall_if     (w_stall),
    .branch_taken (w_branch),
    .br_pc4       (w_br_pc4),
    .br_imm16     (w_br_imm16),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_ack     (w_ack),
    .imem_rdata   (w_rdata),
    .ifid_inst    (w_inst),
    .ifid_pc4     (w_pc4),
    .ifid_valid   (w_valid)
  );

  // Memory models: data = address; main memory answers after lat waits.
  always @(negedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = imem_addr;
  assign w_ack      = w_req;
  assign w_rdata    = w_addr;

  // Monitor: ID consumes IF/ID on an edge where it is valid, not stalled
  // and not flushed by a branch.
  always @(posedge clk) begin
    if (!rst && ifid_valid && !stall_if && !branch_taken) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual inst=%h pc4=%h required none", ifid_inst, ifid_pc4);
      end else begin
        mon_e = q.pop_front();
        if (ifid_inst !== mon_e.inst || ifid_pc4 !== mon_e.pc4) begin
          errors++;
          $display("FAIL sb_ifid actual inst=%h pc4=%h required inst=%h pc4=%h",
                   ifid_inst, ifid_pc4, mon_e.inst, mon_e.pc4);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    q.push_back({a, a + 32'd4});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_inst", ifid_inst, 32'h0);
    chk("rst_pc4", ifid_pc4, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wrap_valid", {31'b0, w_valid}, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    stall_if = 1'b0;
    branch_taken = 1'b0;
    br_pc4 = 32'h0;
    br_imm16 = 16'h0;
    lat = 0;
    #1;
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    stall_if = 1'b0;
    branch_taken = 1'b0;
    br_pc4 = 32'h0;
    br_imm16 = 16'h0;
    lat = 0;
    w_stall = 1'b0;
    w_branch = 1'b0;
    w_br_pc4 = 32'h0;
    w_br_imm16 = 16'h0;

    // T1/T2/T6: reset, zero-wait streaming, PC wrap on second instance
    do_reset();
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    tick();
    chk("t2_inst0", ifid_inst, 32'h0);
    chk("t2_addr1", imem_addr, 32'h4);
    chk("t6_wrap_inst", w_inst, 32'hFFFF_FFFC);
    chk("t6_wrap_pc4", w_pc4, 32'h0);
    chk("t6_wrap_addr", w_addr, 32'h0);
    repeat (4) tick();
    stall_if = 1'b1;
    chk("t2_drained", q.size(), 32'd0);

    // T3: stall as the ack for addr 8 arrives
    do_reset();
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    tick();
    tick();
    stall_if = 1'b1;
    tick();
    chk("t3_hold_req", {31'b0, imem_req}, 32'd0);
    chk("t3_hold_inst", ifid_inst, 32'h4);
    chk("t3_hold_valid", {31'b0, ifid_valid}, 32'd1);
    chk("t3_hold_addr", imem_addr, 32'hC);
    tick();
    tick();
    chk("t3_still_inst", ifid_inst, 32'h4);
    stall_if = 1'b0;
    tick();
    chk("t3_rel_inst", ifid_inst, 32'h8);
    chk("t3_rel_req", {31'b0, imem_req}, 32'd1);
    chk("t3_rel_addr", imem_addr, 32'hC);
    tick();
    tick();
    stall_if = 1'b1;
    chk("t3_drained", q.size(), 32'd0);

    // T4: branch beats stall, negative offset
    do_reset();
    for (int k = 0; k < 7; k++) push(32'(4 * k));
    push(32'hC);
    repeat (8) tick();
    chk("t4_pc20", imem_addr, 32'h20);
    branch_taken = 1'b1;
    br_pc4 = 32'h10;
    br_imm16 = 16'hFFFF;
    stall_if = 1'b1;
    tick();
    chk("t4_bubble_valid", {31'b0, ifid_valid}, 32'd0);
    chk("t4_bubble_inst", ifid_inst, 32'h0);
    chk("t4_target", imem_addr, 32'hC);
    chk("t4_req", {31'b0, imem_req}, 32'd1);
    branch_taken = 1'b0;
    stall_if = 1'b0;
    tick();
    chk("t4_tgt_inst", ifid_inst, 32'hC);
    tick();
    stall_if = 1'b1;
    chk("t4_drained", q.size(), 32'd0);

    // T5: redirect while a 3-wait fetch of 0x40 is outstanding
    do_reset();
    for (int k = 0; k < 15; k++) push(32'(4 * k));
    push(32'h100);
    repeat (16) tick();
    lat = 3;
    branch_taken = 1'b1;
    br_pc4 = 32'h100;
    br_imm16 = 16'h0;
    tick();
    branch_taken = 1'b0;
    chk("t5_drain_addr", imem_addr, 32'h40);
    chk("t5_drain_req", {31'b0, imem_req}, 32'd1);
    chk("t5_drain_valid", {31'b0, ifid_valid}, 32'd0);
    tick();
    tick();
    chk("t5_frozen_addr", imem_addr, 32'h40);
    chk("t5_ack", {31'b0, imem_ack}, 32'd1);
    tick();
    chk("t5_new_addr", imem_addr, 32'h100);
    chk("t5_new_req", {31'b0, imem_req}, 32'd1);
    chk("t5_discard_valid", {31'b0, ifid_valid}, 32'd0);
    lat = 0;
    tick();
    tick();
    stall_if = 1'b1;
    chk("t5_drained", q.size(), 32'd0);

    // T7: second redirect during DRAIN wins
    do_reset();
    lat = 2;
    branch_taken = 1'b1;
    br_pc4 = 32'h10;
    br_imm16 = 16'h0004;
    tick();
    br_pc4 = 32'h80;
    br_imm16 = 16'hFFFE;
    tick();
    branch_taken = 1'b0;
    chk("t7_frozen_addr", imem_addr, 32'h0);
    chk("t7_req", {31'b0, imem_req}, 32'd1);
    tick();
    stall_if = 1'b1;
    chk("t7_latest_target", imem_addr, 32'h78);
    chk("t7_discard_valid", {31'b0, ifid_valid}, 32'd0);

    tick();
    chk("final_q_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
